// File: rtl/dco_cnt_pkg.sv
// dco_cnt_pkg
//   Shared types and defaults for the dco event counter slice.
//   dco_cnt_state_t : report FSM encoding (IDLE / COUNT / REPORT)
//   DCO_CNT_W_DEF   : default counter / threshold / report width
package dco_cnt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    REPORT
  } dco_cnt_state_t;

  localparam int unsigned DCO_CNT_W_DEF = 8;

endpackage

// File: rtl/dco_edge_det.sv
// dco_edge_det
//   Rising-edge detector for the dco event line. The input is already in
//   the clkAB domain, so this is a single delay flop and no synchroniser.
//   The delayed copy is updated every cycle, independent of enable or FSM
//   state, so an input held high across an enable change never looks like
//   a new edge.
// Ports:
//   clkAB : clock
//   rst   : synchronous active-high reset (delayed copy cleared to 0)
//   d     : event input
//   rise  : d & ~d_delayed (combinational, consumed by registered logic)
module dco_edge_det (
  input  logic clkAB,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic r_dco_q;

  always_ff @(posedge clkAB) begin
    if (rst) begin
      r_dco_q <= 1'b0;
    end else begin
      r_dco_q <= d;
    end
  end

  // Delayed copy resets low: a d already high on the first cycle after
  // reset is treated as an edge.
  assign rise = d & ~r_dco_q;

endmodule

// File: rtl/dco_event_counter.sv
// dco_event_counter
//   Counts rising edges of the upstream dco signal in a programmable window
//   and issues a valid/ready report each time the count reaches thresh.
//   Completions that occur while an unaccepted report is pending raise a
//   sticky overflow flag.
// Parameters:
//   CNT_W : counter, threshold and report width
//   SAT   : free-run behaviour at all-ones when thresh = 0
//           (1 = saturate, 0 = wrap to 0)
// Ports:
//   clkAB     in  clock (same muxed clock as the upstream stage)
//   rst       in  synchronous active-high reset
//   dco_in    in  event input
//   en        in  count enable
//   clr       in  synchronous clear of count and ovf
//   thresh    in  report threshold, 0 disables reporting
//   count     out current window count
//   hit       out one-cycle pulse when a window completes
//   ovf       out sticky: a report was lost
//   rpt_valid out report available
//   rpt_ready in  consumer accepts report
//   rpt_count out reported value (thresh at capture)
module dco_event_counter
  import dco_cnt_pkg::*;
#(
  parameter int unsigned CNT_W = DCO_CNT_W_DEF,
  parameter bit          SAT   = 1'b1
) (
  input  logic             clkAB,
  input  logic             rst,
  input  logic             dco_in,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] thresh,
  output logic [CNT_W-1:0] count,
  output logic             hit,
  output logic             ovf,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [CNT_W-1:0] rpt_count
);

  dco_cnt_state_t r_state;
  dco_cnt_state_t w_state_nxt;

  logic             w_rise;
  logic             w_count_rise;
  logic             w_thresh_zero;
  logic             w_at_max;
  logic             w_complete;
  logic             w_handshake;
  logic             w_report_load;
  logic [CNT_W-1:0] w_count_inc;
  logic [CNT_W-1:0] w_count_nxt;

  logic [CNT_W-1:0] r_count;
  logic             r_hit;
  logic             r_ovf;
  logic             r_rpt_valid;
  logic [CNT_W-1:0] r_rpt_count;

  dco_edge_det u_edge_det (
    .clkAB (clkAB),
    .rst   (rst),
    .d     (dco_in),
    .rise  (w_rise)
  );

  // Edges are counted exactly when en is high. In IDLE (en = 0) and in
  // REPORT with en = 0 this ignores edges; an IDLE cycle with en = 1 is
  // the entry cycle into COUNT and its edge is counted, which lets an edge
  // on the first cycle after reset register.
  assign w_count_rise  = en & w_rise & ~clr;
  assign w_thresh_zero = (thresh == '0);
  assign w_at_max      = (r_count == '1);
  assign w_count_inc   = r_count + CNT_W'(1);

  // The increment wraps inside CNT_W, so a thresh lowered below the
  // current count cannot match until the counter rolls past all-ones.
  assign w_complete  = w_count_rise & ~w_thresh_zero & (w_count_inc == thresh);
  assign w_handshake = r_rpt_valid & rpt_ready;

  // A new report may be captured if the slot is free or is being emptied
  // by a handshake on this same edge.
  assign w_report_load = w_complete & (~r_rpt_valid | rpt_ready);

  always_comb begin
    w_count_nxt = r_count;
    if (clr) begin
      w_count_nxt = '0;
    end else if (w_complete) begin
      w_count_nxt = '0;
    end else if (w_count_rise) begin
      // Saturation only applies to free-run mode; with a live threshold
      // the counter must wrap so a lowered thresh is eventually reached.
      if (w_at_max && w_thresh_zero && SAT) begin
        w_count_nxt = r_count;
      end else begin
        w_count_nxt = w_count_inc;
      end
    end
  end

  always_ff @(posedge clkAB) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (en) begin
          w_state_nxt = w_complete ? REPORT : COUNT;
        end
      end
      COUNT: begin
        if (w_complete) begin
          w_state_nxt = REPORT;
        end else if (!en) begin
          w_state_nxt = IDLE;
        end
      end
      REPORT: begin
        // A completion coinciding with the handshake reloads the report
        // and keeps the FSM here.
        if (w_handshake && !w_complete) begin
          w_state_nxt = en ? COUNT : IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clkAB) begin
    if (rst) begin
      r_count     <= '0;
      r_hit       <= 1'b0;
      r_ovf       <= 1'b0;
      r_rpt_valid <= 1'b0;
      r_rpt_count <= '0;
    end else begin
      r_count <= w_count_nxt;
      r_hit   <= w_complete;

      if (clr) begin
        r_ovf <= 1'b0;
      end else if (w_complete && r_rpt_valid && !rpt_ready) begin
        r_ovf <= 1'b1;
      end

      if (w_report_load) begin
        r_rpt_valid <= 1'b1;
        r_rpt_count <= thresh;
      end else if (w_handshake) begin
        r_rpt_valid <= 1'b0;
      end
    end
  end

  assign count     = r_count;
  assign hit       = r_hit;
  assign ovf       = r_ovf;
  assign rpt_valid = r_rpt_valid;
  assign rpt_count = r_rpt_count;

endmodule

// File: tb/tb_dco_event_counter.sv
// tb_dco_event_counter
//   Directed test of dco_event_counter: threshold reports, lost reports,
//   same-cycle handshake and completion, clear/enable gating, reset
//   mid-report, and 4-bit free-run saturate/wrap instances.
module tb_dco_event_counter;

  logic       clkAB = 1'b0;
  logic       rst;
  logic       dco_in;
  logic       en;
  logic       en4;
  logic       clr;
  logic       rpt_ready;
  logic [7:0] thresh;
  logic [7:0] count;
  logic [7:0] rpt_count;
  logic       hit;
  logic       ovf;
  logic       rpt_valid;

  logic [3:0] thresh4;
  logic [3:0] count4s, rpt_count4s, count4w, rpt_count4w;
  logic       hit4s, ovf4s, rpt_valid4s;
  logic       hit4w, ovf4w, rpt_valid4w;

  int checks = 0;
  int errors = 0;

  always #5 clkAB = ~clkAB;

  dco_event_counter #(.CNT_W(8), .SAT(1'b1)) dut (
    .clkAB(clkAB), .rst(rst), .dco_in(dco_in), .en(en), .clr(clr),
    .thresh(thresh), .count(count), .hit(hit), .ovf(ovf),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_count(rpt_count)
  );

  dco_event_counter #(.CNT_W(4), .SAT(1'b1)) dut4s (
    .clkAB(clkAB), .rst(rst), .dco_in(dco_in), .en(en4), .clr(clr),
    .thresh(thresh4), .count(count4s), .hit(hit4s), .ovf(ovf4s),
    .rpt_valid(rpt_valid4s), .rpt_ready(rpt_ready), .rpt_count(rpt_count4s)
  );

  dco_event_counter #(.CNT_W(4), .SAT(1'b0)) dut4w (
    .clkAB(clkAB), .rst(rst), .dco_in(dco_in), .en(en4), .clr(clr),
    .thresh(thresh4), .count(count4w), .hit(hit4w), .ovf(ovf4w),
    .rpt_valid(rpt_valid4w), .rpt_ready(rpt_ready), .rpt_count(rpt_count4w)
  );

  task automatic tick();
    @(posedge clkAB);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; dco_in = 1'b0; en = 1'b0; en4 = 1'b0; clr = 1'b0;
    rpt_ready = 1'b0; thresh = 8'd0; thresh4 = 4'd0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_count", {24'd0, count}, 32'd0);
    chk("rst_hit", {31'd0, hit}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_valid", {31'd0, rpt_valid}, 32'd0);
    chk("rst_rcount", {24'd0, rpt_count}, 32'd0);

    // Threshold report: thresh 3, consumer always ready
    en = 1'b1; thresh = 8'd3; rpt_ready = 1'b1;
    tick();
    dco_in = 1'b1; tick();
    chk("t1_count1", {24'd0, count}, 32'd1);
    chk("t1_hit_a", {31'd0, hit}, 32'd0);
    dco_in = 1'b0; tick();
    dco_in = 1'b1; tick();
    chk("t1_count2", {24'd0, count}, 32'd2);
    dco_in = 1'b0; tick();
    dco_in = 1'b1; tick();
    chk("t1_count0", {24'd0, count}, 32'd0);
    chk("t1_hit", {31'd0, hit}, 32'd1);
    chk("t1_valid", {31'd0, rpt_valid}, 32'd1);
    chk("t1_rcount", {24'd0, rpt_count}, 32'd3);
    dco_in = 1'b0; tick();
    chk("t1_hit_end", {31'd0, hit}, 32'd0);
    chk("t1_valid_end", {31'd0, rpt_valid}, 32'd0);

    // Lost report: thresh 2, consumer stalled over four rises
    thresh = 8'd2; rpt_ready = 1'b0;
    dco_in = 1'b1; tick(); dco_in = 1'b0; tick();
    chk("t2_count1", {24'd0, count}, 32'd1);
    dco_in = 1'b1; tick();
    chk("t2_valid", {31'd0, rpt_valid}, 32'd1);
    chk("t2_rcount", {24'd0, rpt_count}, 32'd2);
    dco_in = 1'b0; tick();
    dco_in = 1'b1; tick(); dco_in = 1'b0; tick();
    chk("t2_ovf_before", {31'd0, ovf}, 32'd0);
    dco_in = 1'b1; tick();
    chk("t2_ovf", {31'd0, ovf}, 32'd1);
    chk("t2_hit_lost", {31'd0, hit}, 32'd1);
    chk("t2_count_lost", {24'd0, count}, 32'd0);
    chk("t2_valid_held", {31'd0, rpt_valid}, 32'd1);
    dco_in = 1'b0; rpt_ready = 1'b1; tick();
    chk("t2_valid_drop", {31'd0, rpt_valid}, 32'd0);
    chk("t2_ovf_sticky", {31'd0, ovf}, 32'd1);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("t2_ovf_clr", {31'd0, ovf}, 32'd0);

    // Same-cycle handshake and completion
    rpt_ready = 1'b0;
    dco_in = 1'b1; tick(); dco_in = 1'b0; tick();
    dco_in = 1'b1; tick(); dco_in = 1'b0; tick();
    chk("t3_pending", {24'd0, rpt_count}, 32'd2);
    thresh = 8'd1; rpt_ready = 1'b1; dco_in = 1'b1; tick();
    chk("t3_valid_kept", {31'd0, rpt_valid}, 32'd1);
    chk("t3_reload", {24'd0, rpt_count}, 32'd1);
    chk("t3_no_ovf", {31'd0, ovf}, 32'd0);
    dco_in = 1'b0; tick();
    chk("t3_valid_fall", {31'd0, rpt_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      dco_in = 1'b1; tick();
      chk("t3_tog_hit", {31'd0, hit}, 32'd1);
      chk("t3_tog_valid", {31'd0, rpt_valid}, 32'd1);
      dco_in = 1'b0; tick();
      chk("t3_tog_valid_lo", {31'd0, rpt_valid}, 32'd0);
    end
    chk("t3_tog_ovf", {31'd0, ovf}, 32'd0);

    // Clear and enable gating
    thresh = 8'd5;
    dco_in = 1'b1; tick(); dco_in = 1'b0; tick();
    chk("t4_count1", {24'd0, count}, 32'd1);
    clr = 1'b1; dco_in = 1'b1; tick();
    chk("t4_clr_rise", {24'd0, count}, 32'd0);
    chk("t4_clr_hit", {31'd0, hit}, 32'd0);
    clr = 1'b0; dco_in = 1'b0; tick();
    dco_in = 1'b1; tick(); dco_in = 1'b0; tick();
    chk("t4_after_clr", {24'd0, count}, 32'd1);
    en = 1'b0;
    dco_in = 1'b1; tick(); dco_in = 1'b0; tick();
    dco_in = 1'b1; tick(); dco_in = 1'b0; tick();
    chk("t4_en_off", {24'd0, count}, 32'd1);
    dco_in = 1'b1; tick();
    en = 1'b1; tick(); tick();
    chk("t4_held_high", {24'd0, count}, 32'd1);
    dco_in = 1'b0; tick();

    // Reset mid-report: build count 2 with a pending report
    thresh = 8'd2; rpt_ready = 1'b0;
    dco_in = 1'b1; tick(); dco_in = 1'b0; tick();
    chk("t5_valid", {31'd0, rpt_valid}, 32'd1);
    thresh = 8'd5;
    dco_in = 1'b1; tick(); dco_in = 1'b0; tick();
    dco_in = 1'b1; tick(); dco_in = 1'b0; tick();
    chk("t5_count2", {24'd0, count}, 32'd2);
    rst = 1'b1; dco_in = 1'b1; tick();
    chk("t5_rst_count", {24'd0, count}, 32'd0);
    chk("t5_rst_valid", {31'd0, rpt_valid}, 32'd0);
    chk("t5_rst_rcount", {24'd0, rpt_count}, 32'd0);
    chk("t5_rst_hit", {31'd0, hit}, 32'd0);
    chk("t5_rst_ovf", {31'd0, ovf}, 32'd0);
    rst = 1'b0; tick();
    chk("t5_first_rise", {24'd0, count}, 32'd1);
    dco_in = 1'b0; tick();

    // 4-bit free-run: saturate vs wrap
    en = 1'b0; en4 = 1'b1; thresh4 = 4'd0;
    for (int i = 0; i < 15; i++) begin
      dco_in = 1'b1; tick(); dco_in = 1'b0; tick();
    end
    chk("t6_sat_15", {28'd0, count4s}, 32'd15);
    chk("t6_wrap_15", {28'd0, count4w}, 32'd15);
    for (int i = 0; i < 2; i++) begin
      dco_in = 1'b1; tick(); dco_in = 1'b0; tick();
    end
    chk("t6_sat_17", {28'd0, count4s}, 32'd15);
    chk("t6_wrap_17", {28'd0, count4w}, 32'd1);
    chk("t6_sat_novalid", {31'd0, rpt_valid4s}, 32'd0);
    chk("t6_wrap_novalid", {31'd0, rpt_valid4w}, 32'd0);
    chk("t6_main_gated", {24'd0, count}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
